// File: rtl/ring_slot_arbiter.sv
// ring_slot_arbiter: round-robin arbiter for one shared slot among N requesters.
// A one-hot ring pointer holds the priority. Grants are registered and held
// until the winner drops its request. There is always at least one IDLE cycle
// between two grants.
// Optional feature macro: RING_ARB_TIMEOUT_EN. When it is defined, a grant is
// forcibly revoked after MAX_HOLD cycles and o_timeout pulses for one cycle.
module ring_slot_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8,
    parameter int IDW      = $clog2(N)
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    input  logic [N-1:0]   i_req,
    output logic [N-1:0]   o_grant,
    output logic           o_grant_valid,
    output logic [IDW-1:0] o_grant_id,
    output logic [N-1:0]   o_ptr,
    output logic           o_timeout
);

    localparam logic [N-1:0] PTR_RESET = {{(N-1){1'b0}}, 1'b1};

    // Reject illegal parameter values when the design is elaborated.
    generate
        if (N < 2 || N > 16) begin : g_bad_n
            $error("ring_slot_arbiter: N must be within 2..16");
        end
        if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_hold
            $error("ring_slot_arbiter: MAX_HOLD must be within 2..256");
        end
    endgenerate

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t         r_state;
    logic [N-1:0]   r_grant;
    logic           r_grant_valid;
    logic [IDW-1:0] r_grant_id;
    logic [N-1:0]   r_ptr;

    logic           w_found;
    logic [IDW-1:0] w_win_id;
    logic [N-1:0]   w_win_oh;
    logic [N-1:0]   w_next_ptr;
    logic           w_owner_req;

`ifdef RING_ARB_TIMEOUT_EN
    localparam int             HW        = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);
    logic [HW-1:0] r_hold;
    logic          r_timeout;
`endif

    // Rotational search: distance k from the pointer bit j; the smallest k wins.
    always_comb begin
        w_found  = 1'b0;
        w_win_id = '0;
        w_win_oh = '0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!w_found && r_ptr[j] && i_req[(j + k) % N]) begin
                    w_found                = 1'b1;
                    w_win_id               = IDW'((j + k) % N);
                    w_win_oh[(j + k) % N]  = 1'b1;
                end else begin
                    w_found = w_found;
                end
            end
        end
    end

    // Pointer goes one position past the winner (wraps N-1 -> 0); owner still asking?
    assign w_next_ptr  = {w_win_oh[N-2:0], w_win_oh[N-1]};
    assign w_owner_req = |(i_req & r_grant);

    // Arbitration FSM with all outputs registered.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_grant_id    <= '0;
            r_ptr         <= PTR_RESET;
`ifdef RING_ARB_TIMEOUT_EN
            r_hold        <= '0;
            r_timeout     <= 1'b0;
`endif
        end else begin
`ifdef RING_ARB_TIMEOUT_EN
            r_timeout <= 1'b0;
`endif
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state       <= ST_BUSY;
                        r_grant       <= w_win_oh;
                        r_grant_valid <= 1'b1;
                        r_grant_id    <= w_win_id;
                        r_ptr         <= w_next_ptr;
`ifdef RING_ARB_TIMEOUT_EN
                        r_hold        <= '0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    if (!w_owner_req) begin
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_id    <= '0;
`ifdef RING_ARB_TIMEOUT_EN
                    end else if (r_hold == HOLD_LAST) begin
                        // Owner has had MAX_HOLD cycles: revoke and flag it.
                        r_state       <= ST_IDLE;
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_grant_id    <= '0;
                        r_timeout     <= 1'b1;
                    end else begin
                        r_state <= ST_BUSY;
                        if (r_hold != {HW{1'b1}}) begin
                            r_hold <= r_hold + {{(HW-1){1'b0}}, 1'b1};
                        end
`else
                    end else begin
                        r_state <= ST_BUSY;
`endif
                    end
                end
                default: begin
                    r_state       <= ST_IDLE;
                    r_grant       <= '0;
                    r_grant_valid <= 1'b0;
                    r_grant_id    <= '0;
                    r_ptr         <= PTR_RESET;
                end
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_valid = r_grant_valid;
    assign o_grant_id    = r_grant_id;
    assign o_ptr         = r_ptr;
`ifdef RING_ARB_TIMEOUT_EN
    assign o_timeout     = r_timeout;
`else
    assign o_timeout     = 1'b0;
`endif

endmodule

// File: doc/ring_slot_arbiter.md
# ring_slot_arbiter

- Round-robin arbiter that shares one downstream resource (a shared bus or datapath slot) among N requesters.
- Priority is held in a one-hot rotating pointer that behaves as a ring counter: reset value `0…01`, and it advances past each requester it serves.
- Grants are registered and held until the winner releases its request. A compile-time option adds a forced release after a maximum hold time.
- The block sits between requester logic and the shared resource's enable/select inputs.

## Interface
Parameters:
- `N`, default 4: number of requesters; legal range 2–16.
- `MAX_HOLD`, default 8: maximum consecutive grant cycles per winner; legal range 2–256. Used only with `RING_ARB_TIMEOUT_EN`.
- `IDW`, default `$clog2(N)`: width of `grant_id`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous assert, active-low.
- `req`, in, N: request per requester, bit i = requester i; level-sensitive.
- `grant`, out, N: one-hot grant, or all zero; registered.
- `grant_valid`, out, 1: high whenever `grant` is nonzero.
- `grant_id`, out, IDW: binary index of the granted requester; 0 when `grant_valid` = 0.
- `ptr`, out, N: current one-hot priority pointer, exported for debug and coverage.
- `timeout`, out, 1: one-cycle pulse when a grant is forcibly revoked; tied 0 without the macro.

## Operation
- States:
  - IDLE: no grant active; the arbiter searches for a winner.
  - BUSY: a grant is held.
- Reset values (while `rst` = 0): state IDLE, `grant` 0, `grant_valid` 0, `grant_id` 0, `ptr` = `…0001` (requester 0 highest), hold counter 0, `timeout` 0.
- Arbitration in IDLE, each cycle:
  - Search `req` rotationally, starting at the bit set in `ptr`, then ptr+1, … mod N. The first set bit i wins.
  - Next cycle: `grant` = one-hot(i), `grant_id` = i, state = BUSY, `ptr` = one-hot((i+1) mod N), hold counter = 0.
  - If `req` = 0: stay in IDLE and leave `ptr` unchanged.
- BUSY, granted requester g:
  - If `req[g]` = 1: hold the grant and increment the hold counter. The counter saturates and does not wrap.
  - If `req[g]` = 0: next cycle `grant` = 0, state = IDLE. `ptr` is unchanged because it already points past g.
  - Requests on other bits are ignored while BUSY; there is no preemption.
- `ptr` wraps from bit N-1 to bit 0. It is always exactly one-hot; a zero or multi-hot pointer is a design error.
- Hold counter width is `$clog2(MAX_HOLD)`. It counts completed grant cycles.
- Reset mid-grant: `grant` drops asynchronously and `ptr` returns to `…0001`. There is no memory of the interrupted owner.

## Timing
- Request-to-grant latency: 1 cycle. `req` is sampled at edge t in IDLE, and `grant` is high after edge t.
- Release latency: 1 cycle. Deassertion of `req[g]` is sampled at edge t, and `grant` is low after edge t.
- Minimum one IDLE cycle between consecutive grants, even to a different requester. Back-to-back grants to the same requester are therefore never adjacent.
- Simultaneous release by g and a new request by j at the same edge: j is not granted until the IDLE cycle that follows.
- A request asserted and then dropped while another requester is BUSY is lost. Requesters must hold `req` until granted.
- All outputs are registered. There are no combinational paths from `req` to `grant`.

## Configuration
- `RING_ARB_TIMEOUT_EN` defined:
  - In BUSY, when the hold counter reaches `MAX_HOLD-1` and `req[g]` is still 1, the next edge drops `grant` and forces IDLE.
  - `timeout` pulses high for exactly that cycle.
  - g's grant totals exactly `MAX_HOLD` cycles.
  - `ptr` is already past g, so other waiting requesters win next. g may win again only once no higher-rotation requester is asking.
- `RING_ARB_TIMEOUT_EN` not defined:
  - The hold counter and timeout logic are not present.
  - `timeout` is tied 0.
  - Grants are held indefinitely while `req[g]` = 1.

## Test plan
- Reset, then assert `req` = `1111` → `grant` = `0001` one cycle later, `ptr` = `0010`, `grant_id` = 0, `grant_valid` = 1.
- Keep `req` = `1111` and pulse each owner's `req` low for 1 cycle to release → grant order 0, 1, 2, 3, 0, each grant separated by one all-zero cycle. `ptr` wraps from `1000` to `0001`.
- Sparse requests: with `ptr` = `0100`, drive `req` = `0011` → `grant` = `0001`, then `ptr` = `0010`. Drive `req` = `0000` → IDLE holds and `ptr` stays `0010`.
- Assert `rst` low mid-grant with `grant` = `0100` → `grant`, `grant_valid` and `grant_id` go 0 immediately, without waiting for a clock edge. `ptr` = `0001`. After releasing reset with `req` = `0100`, the grant returns 1 cycle later.
- With `RING_ARB_TIMEOUT_EN` and `MAX_HOLD` = 4, hold `req` = `0011` constantly → `grant` = `0001` for exactly 4 cycles, `timeout` pulses 1 cycle, one IDLE cycle, then `grant` = `0010`.
- Without the macro, hold `req[0]` high for 100 cycles with `req` = `0011` → `grant` stays `0001` throughout and `timeout` stays 0.
